sim_ioctl_loader: RTL

- Simulation-side download sequencer that sits directly upstream of the emu top.
- It drives emu's ioctl_download / ioctl_wr / ioctl_addr / ioctl_dout / ioctl_index bus with HPS-like timing, honours ioctl_wait, and emits a single done pulse at the end.
- The C++ harness pushes ROM/data bytes into an internal FIFO through a valid/ready port and starts a transfer with an index and a byte length.

---
 rtl/sim_ioctl_loader.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/sim_ioctl_loader.sv
// Simulation-side ioctl download sequencer: buffers harness bytes in a FIFO
// and replays them onto the emu ioctl bus with HPS-like pacing.
module sim_ioctl_loader #(
   parameter int FIFO_DEPTH   = 16,
   parameter int SETUP_CYCLES = 4,
   parameter int WR_GAP       = 2,
   parameter int TAIL_CYCLES  = 4
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        start,
   input  logic [7:0]  start_index,
   input  logic [24:0] start_len,
   input  logic        abort,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        busy,
   output logic        done,
   output logic        ioctl_download,
   output logic        ioctl_wr,
   output logic [24:0] ioctl_addr,
   output logic [7:0]  ioctl_dout,
   output logic [7:0]  ioctl_index,
   input  logic        ioctl_wait
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0]  FULL       = (AW+1)'(FIFO_DEPTH);
   localparam logic [15:0]  SETUP_LAST = 16'(SETUP_CYCLES - 1);
   localparam logic [15:0]  TAIL_LAST  = 16'(TAIL_CYCLES - 1);
   localparam logic [7:0]   GAP_INIT   = 8'(WR_GAP);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_ISSUE, S_WRITE, S_TAIL
   } state_t;

   state_t state_q, state_d;

   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0] count_q, count_d;
   logic        in_ready_q, in_ready_d;

   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  gap_q, gap_d;
   logic [24:0] rem_q, rem_d;
   logic [24:0] addr_q, addr_d;
   logic [7:0]  idx_q, idx_d;
   logic [7:0]  dout_q, dout_d;
   logic        wr_q_o, wr_d_o;
   logic        dl_q, dl_d;
   logic        done_q, done_d;

   logic push, pop;

   // Abort drops any concurrent push as part of the flush.
   assign push = in_valid & in_ready_q & ~abort;
   assign pop  = (state_q == S_ISSUE) & (count_q != '0) & ~ioctl_wait
               & (gap_q == 8'd0) & ~abort;

   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (abort) begin
         wr_d    = '0;
         rd_d    = '0;
         count_d = '0;
      end else begin
         if (push) wr_d = wr_q + 1'b1;
         if (pop)  rd_d = rd_q + 1'b1;
         count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
      end
      in_ready_d = (count_d != FULL);
   end

   always_ff @(posedge clk_sys) begin
      if (push) mem_q[wr_q] <= in_data;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         wr_q       <= '0;
         rd_q       <= '0;
         count_q    <= '0;
         in_ready_q <= 1'b1;
         cnt_q      <= '0;
         gap_q      <= '0;
         rem_q      <= '0;
         addr_q     <= '0;
         idx_q      <= '0;
         dout_q     <= '0;
         wr_q_o     <= 1'b0;
         dl_q       <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         count_q    <= count_d;
         in_ready_q <= in_ready_d;
         cnt_q      <= cnt_d;
         gap_q      <= gap_d;
         rem_q      <= rem_d;
         addr_q     <= addr_d;
         idx_q      <= idx_d;
         dout_q     <= dout_d;
         wr_q_o     <= wr_d_o;
         dl_q       <= dl_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_SETUP;
         S_SETUP: if (cnt_q == SETUP_LAST)
                     state_d = (rem_q == '0) ? S_TAIL : S_ISSUE;
         S_ISSUE: if (pop) state_d = S_WRITE;
         S_WRITE: state_d = (rem_q == 25'd1) ? S_TAIL : S_ISSUE;
         S_TAIL:  if (cnt_q == TAIL_LAST) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort) state_d = S_IDLE;
   end

   always_comb begin
      cnt_d  = cnt_q;
      gap_d  = gap_q;
      rem_d  = rem_q;
      addr_d = addr_q;
      idx_d  = idx_q;
      dout_d = dout_q;
      wr_d_o = 1'b0;
      dl_d   = dl_q;
      done_d = 1'b0;
      unique case (state_q)
         S_IDLE: if (start && !abort) begin
            idx_d  = start_index;
            rem_d  = start_len;
            addr_d = '0;
            cnt_d  = '0;
            gap_d  = '0;
            dl_d   = 1'b1;
         end
         S_SETUP: cnt_d = (cnt_q == SETUP_LAST) ? 16'd0 : cnt_q + 16'd1;
         S_ISSUE: begin
            if (gap_q != 8'd0) gap_d = gap_q - 8'd1;
            if (pop) begin
               wr_d_o = 1'b1;
               dout_d = mem_q[rd_q];
            end
         end
         S_WRITE: begin
            addr_d = addr_q + 25'd1;
            rem_d  = rem_q - 25'd1;
            gap_d  = GAP_INIT;
            cnt_d  = '0;
         end
         S_TAIL: begin
            if (cnt_q == TAIL_LAST) begin
               cnt_d  = '0;
               dl_d   = 1'b0;
               done_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: ;
      endcase
      if (abort) begin
         cnt_d  = '0;
         gap_d  = '0;
         wr_d_o = 1'b0;
         dl_d   = 1'b0;
         done_d = 1'b0;
      end
   end

   assign in_ready       = in_ready_q;
   assign busy           = (state_q != S_IDLE);
   assign done           = done_q;
   assign ioctl_download = dl_q;
   assign ioctl_wr       = wr_q_o;
   assign ioctl_addr     = addr_q;
   assign ioctl_dout     = dout_q;
   assign ioctl_index    = idx_q;

endmodule
